mem_port_arbiter: RTL

Shares the single data-memory port between the CPU's X-stage memory interface and a secondary bus master, such as the accelerator or DMA, that uses a req/gnt handshake. The block sits between the CPU core and the data memory. It stalls the CPU pipeline through the CPU enable whenever the CPU loses arbitration. It also holds CPU load data stable across stalls so the M-stage read still sees the correct word.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_port_arbiter_if.sv | 23 ++
 rtl/mem_arb_sat_cnt.sv | 26 ++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and bus widths for the data-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic {
        CPU_PRI = 1'b0,
        ACC_PRI = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Accelerator/DMA req/gnt bus: the master issues requests, the arbiter is the slave.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              acc_req;
    logic [BE_W-1:0]   acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_gnt;
    logic              acc_rvalid;
    logic [DATA_W-1:0] acc_rdata;

    modport master (
        output acc_req, acc_we, acc_addr, acc_wdata,
        input  acc_gnt, acc_rvalid, acc_rdata
    );

    modport slave (
        input  acc_req, acc_we, acc_addr, acc_wdata,
        output acc_gnt, acc_rvalid, acc_rdata
    );

endinterface

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; en low freezes the count.
module mem_arb_sat_cnt #(
    parameter int unsigned   W   = 4,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) begin
                q <= '0;
            end else if (inc && (q != MAX)) begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the data-memory port between the CPU X stage and an accelerator.
// Optional performance counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ACC_WAIT_MAX  = 4,
    parameter int unsigned ACC_BURST_MAX = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              cpu_en,
    input  logic              cpu_read_en,
    input  logic [BE_W-1:0]   cpu_write_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    mem_port_arbiter_if.slave acc,
    output logic              mem_read_en,
    output logic [BE_W-1:0]   mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [CNT_W-1:0]  perf_cpu_stall,
    output logic [CNT_W-1:0]  perf_acc_gnt
);

    localparam int unsigned WAIT_W  = $clog2(ACC_WAIT_MAX + 1);
    localparam int unsigned BURST_W = $clog2(ACC_BURST_MAX + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(ACC_WAIT_MAX - 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(ACC_BURST_MAX);

    arb_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic [DATA_W-1:0] hold_reg;
    logic              cpu_rd_last;
    logic              acc_rvalid_q;

    logic cpu_req, cpu_win, acc_win, cpu_gnt, acc_gnt;
    logic wait_clr, wait_inc, burst_clr, burst_inc;
    logic to_acc, to_cpu;

    assign cpu_req = cpu_read_en | (|cpu_write_en);

    always_comb begin
        cpu_win   = 1'b0;
        acc_win   = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        burst_clr = 1'b0;
        burst_inc = 1'b0;
        to_acc    = 1'b0;
        to_cpu    = 1'b0;
        case (state)
            CPU_PRI: begin
                if (cpu_req && acc.acc_req) begin
                    if (wait_cnt < WAIT_LAST) begin
                        cpu_win  = 1'b1;
                        wait_inc = 1'b1;
                    end else begin
                        // burst_cnt is always 0 in CPU_PRI, so incrementing loads 1
                        acc_win   = 1'b1;
                        wait_clr  = 1'b1;
                        burst_inc = 1'b1;
                        to_acc    = 1'b1;
                    end
                end else if (acc.acc_req) begin
                    acc_win  = 1'b1;
                    wait_clr = 1'b1;
                end else begin
                    cpu_win  = cpu_req;
                    wait_clr = 1'b1;
                end
            end
            ACC_PRI: begin
                if (acc.acc_req && ((burst_cnt < BURST_LIM) || !cpu_req)) begin
                    acc_win   = 1'b1;
                    burst_inc = 1'b1;
                end else begin
                    cpu_win   = cpu_req;
                    burst_clr = 1'b1;
                    to_cpu    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cpu_gnt = en & cpu_win;
    assign acc_gnt = en & acc.acc_req & acc_win;
    assign cpu_en  = en & ~(cpu_req & ~cpu_gnt);

    always_comb begin
        mem_read_en    = 1'b0;
        mem_write_en   = '0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (cpu_gnt) begin
            mem_read_en    = cpu_read_en;
            mem_write_en   = cpu_write_en;
            mem_addr       = cpu_addr;
            mem_write_data = cpu_wdata;
        end else if (acc_gnt) begin
            mem_read_en    = ~(|acc.acc_we);
            mem_write_en   = acc.acc_we;
            mem_addr       = acc.acc_addr;
            mem_write_data = acc.acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CPU_PRI;
            hold_reg     <= '0;
            cpu_rd_last  <= 1'b0;
            acc_rvalid_q <= 1'b0;
        end else if (en) begin
            if (to_acc) begin
                state <= ACC_PRI;
            end else if (to_cpu) begin
                state <= CPU_PRI;
            end
            cpu_rd_last  <= cpu_gnt & cpu_read_en;
            acc_rvalid_q <= acc_gnt & ~(|acc.acc_we);
            if (cpu_rd_last) begin
                hold_reg <= mem_read_data;
            end
        end
    end

    // Stall cycles only ever show the last CPU load word, never accelerator data.
    assign cpu_rdata      = cpu_rd_last ? mem_read_data : hold_reg;
    assign acc.acc_gnt    = acc_gnt;
    assign acc.acc_rvalid = acc_rvalid_q;
    assign acc.acc_rdata  = acc_rvalid_q ? mem_read_data : '0;

    mem_arb_sat_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk), .rst (rst), .en (en),
        .clr (wait_clr), .inc (wait_inc), .q (wait_cnt)
    );

    mem_arb_sat_cnt #(.W(BURST_W), .MAX(BURST_LIM)) u_burst_cnt (
        .clk (clk), .rst (rst), .en (en),
        .clr (burst_clr), .inc (burst_inc), .q (burst_cnt)
    );

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_sat_cnt #(.W(CNT_W)) u_perf_cpu_stall (
        .clk (clk), .rst (rst), .en (1'b1),
        .clr (1'b0), .inc (en & cpu_req & ~cpu_gnt), .q (perf_cpu_stall)
    );

    mem_arb_sat_cnt #(.W(CNT_W)) u_perf_acc_gnt (
        .clk (clk), .rst (rst), .en (1'b1),
        .clr (1'b0), .inc (acc_gnt), .q (perf_acc_gnt)
    );
`else
    assign perf_cpu_stall = '0;
    assign perf_acc_gnt   = '0;
`endif

endmodule
